// File: rtl/cram_async_ctrl.sv
// Asynchronous-mode controller for the ADMUX x16 cellular RAM: valid/ready word requests in, timed pin sequence out.
// Optional configuration-register access is enabled by defining CRAM_CFG_EN (adds req_cfg input).
module cram_async_ctrl #(
   parameter int NUM_DIES = 2,
   parameter int T_ADV    = 2,
   parameter int T_RD     = 6,
   parameter int T_WR     = 6,
   parameter int T_REC    = 2,
   localparam int ADDR_W  = 22 + ((NUM_DIES == 2) ? 1 : 0)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [15:0]       req_wdata,
   input  logic [1:0]        req_be,
`ifdef CRAM_CFG_EN
   input  logic              req_cfg,
`endif
   output logic              rsp_valid,
   output logic [15:0]       rsp_rdata,
   output logic [5:0]        cram_a,
   output logic [15:0]       cram_dq_out,
   input  logic [15:0]       cram_dq_in,
   output logic              cram_dq_oe,
   output logic              cram_clk,
   output logic              cram_adv_n,
   output logic              cram_cre,
   output logic              cram_ce0_n,
   output logic              cram_ce1_n,
   output logic              cram_oe_n,
   output logic              cram_we_n,
   output logic              cram_ub_n,
   output logic              cram_lb_n
);

   localparam int MAXT_A = (T_ADV > T_RD) ? T_ADV : T_RD;
   localparam int MAXT_B = (T_WR > T_REC) ? T_WR : T_REC;
   localparam int MAXT   = (MAXT_A > MAXT_B) ? MAXT_A : MAXT_B;
   localparam int CNT_W  = (MAXT > 1) ? $clog2(MAXT) : 1;

   localparam logic [CNT_W-1:0] LD_ADV = CNT_W'(T_ADV - 1);
   localparam logic [CNT_W-1:0] LD_RD  = CNT_W'(T_RD - 1);
   localparam logic [CNT_W-1:0] LD_WR  = CNT_W'(T_WR - 1);
   localparam logic [CNT_W-1:0] LD_REC = CNT_W'((T_REC > 0) ? (T_REC - 1) : 0);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_REC} state_t;

   state_t             state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;

   logic               lat_write;
   logic [ADDR_W-1:0]  lat_addr;
   logic [15:0]        lat_wdata;
   logic [1:0]         lat_be;
   logic               lat_cfg;

   logic               accept;
   logic               cur_write;
   logic [ADDR_W-1:0]  cur_addr;
   logic [15:0]        cur_wdata;
   logic [1:0]         cur_be;
   logic               cur_cfg;
   logic               in_cfg;
   logic               rsp_hit;
   logic               active;
   logic               sel1;

   // next-cycle values of every registered output
   logic               ready_d, rsp_valid_d, dq_oe_d, adv_d, cre_d;
   logic               ce0_d, ce1_d, oe_d, we_d, ub_d, lb_d;
   logic [15:0]        rdata_d, dq_out_d;
   logic [5:0]         a_d;

`ifdef CRAM_CFG_EN
   assign in_cfg = req_cfg;
`else
   assign in_cfg = 1'b0;
`endif

   assign cram_clk = 1'b0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      accept    = req_valid && req_ready;
      // on the accept edge the latch is not loaded yet, so drive from the request directly
      cur_write = accept ? req_write : lat_write;
      cur_addr  = accept ? req_addr  : lat_addr;
      cur_wdata = accept ? req_wdata : lat_wdata;
      cur_be    = accept ? req_be    : lat_be;
      cur_cfg   = accept ? in_cfg    : lat_cfg;

      state_n = state;
      cnt_n   = cnt;
      rsp_hit = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_n = S_ADDR;
               cnt_n   = LD_ADV;
            end
         end
         S_ADDR: begin
            if (cnt == '0) begin
               state_n = S_DATA;
               cnt_n   = lat_write ? LD_WR : LD_RD;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         S_DATA: begin
            if (cnt == '0) begin
               rsp_hit = !lat_write;
               if (T_REC == 0) begin
                  state_n = S_IDLE;
               end else begin
                  state_n = S_REC;
                  cnt_n   = LD_REC;
               end
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         S_REC: begin
            if (cnt == '0) state_n = S_IDLE;
            else           cnt_n   = cnt - CNT_W'(1);
         end
         default: state_n = S_IDLE;
      endcase

      active = (state_n == S_ADDR) || (state_n == S_DATA);
      sel1   = (NUM_DIES == 2) && cur_addr[ADDR_W-1];

      ready_d     = (state_n == S_IDLE);
      rsp_valid_d = rsp_hit;
      rdata_d     = rsp_hit ? cram_dq_in : rsp_rdata;
      ce0_d       = !(active && !sel1);
      ce1_d       = !(active && sel1);
      adv_d       = !(state_n == S_ADDR);
      cre_d       = active && cur_cfg;
      a_d         = (state_n == S_ADDR) ? cur_addr[21:16] : cram_a;
      oe_d        = 1'b1;
      we_d        = 1'b1;
      ub_d        = 1'b1;
      lb_d        = 1'b1;
      dq_out_d    = 16'h0000;

      if (state_n == S_ADDR) begin
         dq_out_d = cur_addr[15:0];
      end else if (state_n == S_DATA) begin
         if (cur_write) begin
            we_d     = 1'b0;
            dq_out_d = cur_wdata;
            // register writes must see both lanes enabled
            ub_d     = cur_cfg ? 1'b0 : !cur_be[1];
            lb_d     = cur_cfg ? 1'b0 : !cur_be[0];
         end else begin
            oe_d = 1'b0;
            ub_d = 1'b0;
            lb_d = 1'b0;
         end
      end
      dq_oe_d = oe_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         req_ready   <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= 16'h0000;
         cram_a      <= 6'd0;
         cram_dq_out <= 16'h0000;
         cram_dq_oe  <= 1'b1;
         cram_adv_n  <= 1'b1;
         cram_cre    <= 1'b0;
         cram_ce0_n  <= 1'b1;
         cram_ce1_n  <= 1'b1;
         cram_oe_n   <= 1'b1;
         cram_we_n   <= 1'b1;
         cram_ub_n   <= 1'b1;
         cram_lb_n   <= 1'b1;
      end else begin
         req_ready   <= ready_d;
         rsp_valid   <= rsp_valid_d;
         rsp_rdata   <= rdata_d;
         cram_a      <= a_d;
         cram_dq_out <= dq_out_d;
         cram_dq_oe  <= dq_oe_d;
         cram_adv_n  <= adv_d;
         cram_cre    <= cre_d;
         cram_ce0_n  <= ce0_d;
         cram_ce1_n  <= ce1_d;
         cram_oe_n   <= oe_d;
         cram_we_n   <= we_d;
         cram_ub_n   <= ub_d;
         cram_lb_n   <= lb_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lat_write <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= 16'h0000;
         lat_be    <= 2'b00;
         lat_cfg   <= 1'b0;
      end else if (accept) begin
         lat_write <= req_write;
         lat_addr  <= req_addr;
         lat_wdata <= req_wdata;
         lat_be    <= req_be;
         lat_cfg   <= in_cfg;
      end
   end

endmodule

// File: tb/tb_cram_async_ctrl.sv
module tb_cram_async_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_write;
  logic [22:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic [15:0] cram_dq_in;
`ifdef CRAM_CFG_EN
  logic        req_cfg;
`endif

  logic        req_valid, req_ready, rsp_valid;
  logic [15:0] rsp_rdata, cram_dq_out;
  logic [5:0]  cram_a;
  logic        cram_dq_oe, cram_clk, cram_adv_n, cram_cre, cram_ce0_n, cram_ce1_n;
  logic        cram_oe_n, cram_we_n, cram_ub_n, cram_lb_n;

  logic        req_valid0, req_ready0, rsp_valid0;
  logic [15:0] rsp_rdata0, cram_dq_out0;
  logic [5:0]  cram_a0;
  logic        cram_dq_oe0, cram_clk0, cram_adv_n0, cram_cre0, cram_ce0_n0, cram_ce1_n0;
  logic        cram_oe_n0, cram_we_n0, cram_ub_n0, cram_lb_n0;

  int n_cmp = 0;
  int n_err = 0;
  int adv_c, oe_c, we_c, cre_c, rsp_c, rsp_at, rdy_at, rdy2_at, ce0_c, ovl;

  always #5 clk = ~clk;

  cram_async_ctrl u_dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
`ifdef CRAM_CFG_EN
    .req_cfg(req_cfg),
`endif
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .cram_a(cram_a), .cram_dq_out(cram_dq_out), .cram_dq_in(cram_dq_in),
    .cram_dq_oe(cram_dq_oe), .cram_clk(cram_clk), .cram_adv_n(cram_adv_n),
    .cram_cre(cram_cre), .cram_ce0_n(cram_ce0_n), .cram_ce1_n(cram_ce1_n),
    .cram_oe_n(cram_oe_n), .cram_we_n(cram_we_n), .cram_ub_n(cram_ub_n), .cram_lb_n(cram_lb_n)
  );

  cram_async_ctrl #(.T_REC(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
`ifdef CRAM_CFG_EN
    .req_cfg(req_cfg),
`endif
    .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0),
    .cram_a(cram_a0), .cram_dq_out(cram_dq_out0), .cram_dq_in(cram_dq_in),
    .cram_dq_oe(cram_dq_oe0), .cram_clk(cram_clk0), .cram_adv_n(cram_adv_n0),
    .cram_cre(cram_cre0), .cram_ce0_n(cram_ce0_n0), .cram_ce1_n(cram_ce1_n0),
    .cram_oe_n(cram_oe_n0), .cram_we_n(cram_we_n0), .cram_ub_n(cram_ub_n0), .cram_lb_n(cram_lb_n0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_valid0 = 1'b0;
    req_write  = 1'b0;
    req_addr   = 23'h0;
    req_wdata  = 16'h0;
    req_be     = 2'b11;
    cram_dq_in = 16'h0;
`ifdef CRAM_CFG_EN
    req_cfg    = 1'b0;
`endif

    repeat (10) tick();
    n_cmp++;
    if (req_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: observed %0h required %0h", req_ready, 1'b0); end
    n_cmp++;
    if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: observed %0h required %0h", rsp_valid, 1'b0); end
    n_cmp++;
    if (rsp_rdata !== 16'h0000) begin n_err++; $display("FAIL rst_rdata: observed %0h required %0h", rsp_rdata, 16'h0000); end
    n_cmp++;
    if ({cram_adv_n, cram_ce0_n, cram_ce1_n, cram_oe_n, cram_we_n, cram_ub_n, cram_lb_n} !== 7'h7F) begin
      n_err++; $display("FAIL rst_ctrl_pins: observed %0h required %0h",
        {cram_adv_n, cram_ce0_n, cram_ce1_n, cram_oe_n, cram_we_n, cram_ub_n, cram_lb_n}, 7'h7F);
    end
    n_cmp++;
    if ({cram_dq_oe, cram_dq_out, cram_a} !== {1'b1, 16'h0000, 6'h00}) begin
      n_err++; $display("FAIL rst_dq: observed %0h required %0h", {cram_dq_oe, cram_dq_out, cram_a}, {1'b1, 16'h0000, 6'h00});
    end
    n_cmp++;
    if ({cram_cre, cram_clk} !== 2'b00) begin n_err++; $display("FAIL rst_cre_clk: observed %0h required %0h", {cram_cre, cram_clk}, 2'b00); end
    reset_n = 1'b1;
    tick();
    n_cmp++;
    if (req_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_release: observed %0h required %0h", req_ready, 1'b1); end

    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = 23'h012345;
    cram_dq_in = 16'hBEEF;
    adv_c = 0; oe_c = 0; rsp_c = 0; rsp_at = -1; rdy_at = -1; ce0_c = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 0) begin
        req_valid = 1'b0;
        n_cmp++;
        if (req_ready !== 1'b0) begin n_err++; $display("FAIL rd_accept_ready_low: observed %0h required %0h", req_ready, 1'b0); end
        n_cmp++;
        if ({cram_ce0_n, cram_ce1_n, cram_adv_n, cram_a, cram_dq_out} !== {1'b0, 1'b1, 1'b0, 6'h01, 16'h2345}) begin
          n_err++; $display("FAIL rd_addr_phase: observed %0h required %0h",
            {cram_ce0_n, cram_ce1_n, cram_adv_n, cram_a, cram_dq_out}, {1'b0, 1'b1, 1'b0, 6'h01, 16'h2345});
        end
      end
      if (i == 2) begin
        n_cmp++;
        if ({cram_dq_oe, cram_oe_n, cram_ub_n, cram_lb_n, cram_a} !== {4'b0000, 6'h01}) begin
          n_err++; $display("FAIL rd_data_phase: observed %0h required %0h",
            {cram_dq_oe, cram_oe_n, cram_ub_n, cram_lb_n, cram_a}, {4'b0000, 6'h01});
        end
      end
      if (i == 8) begin
        n_cmp++;
        if ({cram_ce0_n, cram_oe_n, cram_dq_oe} !== 3'b111) begin
          n_err++; $display("FAIL rd_rec_ce_high: observed %0h required %0h", {cram_ce0_n, cram_oe_n, cram_dq_oe}, 3'b111);
        end
      end
      if (!cram_adv_n) adv_c++;
      if (!cram_oe_n) oe_c++;
      if (!cram_ce0_n) ce0_c++;
      if (rsp_valid) begin rsp_c++; if (rsp_at < 0) rsp_at = i; end
      if (req_ready && rdy_at < 0) rdy_at = i;
    end
    n_cmp++;
    if (adv_c !== 2) begin n_err++; $display("FAIL rd_adv_cycles: observed %0h required %0h", adv_c, 2); end
    n_cmp++;
    if (oe_c !== 6) begin n_err++; $display("FAIL rd_oe_cycles: observed %0h required %0h", oe_c, 6); end
    n_cmp++;
    if (ce0_c !== 8) begin n_err++; $display("FAIL rd_ce0_cycles: observed %0h required %0h", ce0_c, 8); end
    n_cmp++;
    if (rsp_at !== 8) begin n_err++; $display("FAIL rd_rsp_at: observed %0h required %0h", rsp_at, 8); end
    n_cmp++;
    if (rsp_c !== 1) begin n_err++; $display("FAIL rd_rsp_count: observed %0h required %0h", rsp_c, 1); end
    n_cmp++;
    if (rsp_rdata !== 16'hBEEF) begin n_err++; $display("FAIL rd_rdata: observed %0h required %0h", rsp_rdata, 16'hBEEF); end
    n_cmp++;
    if (rdy_at !== 10) begin n_err++; $display("FAIL rd_ready_at: observed %0h required %0h", rdy_at, 10); end

    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_addr   = 23'h400010;
    req_wdata  = 16'hA55A;
    req_be     = 2'b01;
    cram_dq_in = 16'h1111;
    we_c = 0; cre_c = 0; rsp_c = 0; rdy_at = -1; ce0_c = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 0) begin
        req_valid = 1'b0;
        n_cmp++;
        if ({cram_ce0_n, cram_ce1_n, cram_adv_n, cram_a, cram_dq_out} !== {1'b1, 1'b0, 1'b0, 6'h00, 16'h0010}) begin
          n_err++; $display("FAIL wr_addr_phase: observed %0h required %0h",
            {cram_ce0_n, cram_ce1_n, cram_adv_n, cram_a, cram_dq_out}, {1'b1, 1'b0, 1'b0, 6'h00, 16'h0010});
        end
      end
      if (i == 2) begin
        n_cmp++;
        if ({cram_we_n, cram_oe_n, cram_dq_oe, cram_ub_n, cram_lb_n, cram_dq_out} !== {5'b01110, 16'hA55A}) begin
          n_err++; $display("FAIL wr_data_phase: observed %0h required %0h",
            {cram_we_n, cram_oe_n, cram_dq_oe, cram_ub_n, cram_lb_n, cram_dq_out}, {5'b01110, 16'hA55A});
        end
      end
      if (!cram_we_n) we_c++;
      if (!cram_ce0_n) ce0_c++;
      if (cram_cre) cre_c++;
      if (rsp_valid) rsp_c++;
      if (req_ready && rdy_at < 0) rdy_at = i;
    end
    n_cmp++;
    if (we_c !== 6) begin n_err++; $display("FAIL wr_we_cycles: observed %0h required %0h", we_c, 6); end
    n_cmp++;
    if (ce0_c !== 0) begin n_err++; $display("FAIL wr_ce0_never: observed %0h required %0h", ce0_c, 0); end
    n_cmp++;
    if (rsp_c !== 0) begin n_err++; $display("FAIL wr_no_rsp: observed %0h required %0h", rsp_c, 0); end
    n_cmp++;
    if (cre_c !== 0) begin n_err++; $display("FAIL wr_cre_zero: observed %0h required %0h", cre_c, 0); end
    n_cmp++;
    if (rdy_at !== 10) begin n_err++; $display("FAIL wr_ready_at: observed %0h required %0h", rdy_at, 10); end
    n_cmp++;
    if (rsp_rdata !== 16'hBEEF) begin n_err++; $display("FAIL wr_rdata_held: observed %0h required %0h", rsp_rdata, 16'hBEEF); end

    n_cmp++;
    if (req_ready0 !== 1'b1) begin n_err++; $display("FAIL b2b_idle_ready: observed %0h required %0h", req_ready0, 1'b1); end
    req_valid0 = 1'b1;
    req_write  = 1'b0;
    req_addr   = 23'h000100;
    req_be     = 2'b11;
    cram_dq_in = 16'hC0DE;
    rdy_at = -1; rdy2_at = -1; rsp_at = -1; ovl = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 0) begin
        req_write = 1'b1;
        req_addr  = 23'h400200;
        req_wdata = 16'h1234;
      end
      if (i == 8) begin
        n_cmp++;
        if ({cram_ce0_n0, cram_ce1_n0} !== 2'b11) begin
          n_err++; $display("FAIL b2b_gap_ce_high: observed %0h required %0h", {cram_ce0_n0, cram_ce1_n0}, 2'b11);
        end
      end
      if (i == 9) begin
        req_valid0 = 1'b0;
        n_cmp++;
        if ({req_ready0, cram_ce1_n0, cram_ce0_n0, cram_adv_n0} !== 4'b0010) begin
          n_err++; $display("FAIL b2b_second_accept: observed %0h required %0h",
            {req_ready0, cram_ce1_n0, cram_ce0_n0, cram_adv_n0}, 4'b0010);
        end
      end
      if (!cram_ce0_n0 && !cram_ce1_n0) ovl++;
      if (rsp_valid0 && rsp_at < 0) rsp_at = i;
      if (req_ready0 && i <= 9 && rdy_at < 0) rdy_at = i;
      if (req_ready0 && i > 9 && rdy2_at < 0) rdy2_at = i;
    end
    n_cmp++;
    if (rdy_at !== 8) begin n_err++; $display("FAIL b2b_ready_rerise: observed %0h required %0h", rdy_at, 8); end
    n_cmp++;
    if (rsp_at !== 8) begin n_err++; $display("FAIL b2b_rsp_at: observed %0h required %0h", rsp_at, 8); end
    n_cmp++;
    if (rsp_rdata0 !== 16'hC0DE) begin n_err++; $display("FAIL b2b_rdata: observed %0h required %0h", rsp_rdata0, 16'hC0DE); end
    n_cmp++;
    if (ovl !== 0) begin n_err++; $display("FAIL b2b_no_ce_overlap: observed %0h required %0h", ovl, 0); end
    n_cmp++;
    if (rdy2_at !== 17) begin n_err++; $display("FAIL b2b_second_done: observed %0h required %0h", rdy2_at, 17); end

    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 23'h400010;
    req_be    = 2'b11;
    tick();
    req_valid = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({cram_we_n, cram_ce1_n} !== 2'b00) begin
      n_err++; $display("FAIL abort_in_data: observed %0h required %0h", {cram_we_n, cram_ce1_n}, 2'b00);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({cram_we_n, cram_ce1_n, cram_ce0_n, req_ready, rsp_valid} !== 5'b11100) begin
      n_err++; $display("FAIL abort_async_pins: observed %0h required %0h",
        {cram_we_n, cram_ce1_n, cram_ce0_n, req_ready, rsp_valid}, 5'b11100);
    end
    rsp_c = 0;
    repeat (2) begin tick(); if (rsp_valid) rsp_c++; end
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin tick(); if (rsp_valid) rsp_c++; end
    n_cmp++;
    if ({req_ready, cram_ce1_n, cram_we_n} !== 3'b111) begin
      n_err++; $display("FAIL abort_idle_ready: observed %0h required %0h", {req_ready, cram_ce1_n, cram_we_n}, 3'b111);
    end
    n_cmp++;
    if (rsp_c !== 0) begin n_err++; $display("FAIL abort_no_rsp: observed %0h required %0h", rsp_c, 0); end

`ifdef CRAM_CFG_EN
    req_valid = 1'b1;
    req_write = 1'b1;
    req_cfg   = 1'b1;
    req_addr  = 23'h081D1F;
    req_be    = 2'b00;
    we_c = 0; cre_c = 0;
    for (int i = 0; i < 11; i++) begin
      tick();
      if (i == 0) begin
        req_valid = 1'b0;
        req_cfg   = 1'b0;
        n_cmp++;
        if ({cram_cre, cram_a, cram_dq_out} !== {1'b1, 6'h08, 16'h1D1F}) begin
          n_err++; $display("FAIL cfg_addr_phase: observed %0h required %0h",
            {cram_cre, cram_a, cram_dq_out}, {1'b1, 6'h08, 16'h1D1F});
        end
      end
      if (i == 2) begin
        n_cmp++;
        if ({cram_ub_n, cram_lb_n, cram_we_n} !== 3'b000) begin
          n_err++; $display("FAIL cfg_lanes: observed %0h required %0h", {cram_ub_n, cram_lb_n, cram_we_n}, 3'b000);
        end
      end
      if (!cram_we_n) we_c++;
      if (cram_cre) cre_c++;
    end
    n_cmp++;
    if (cre_c !== 8) begin n_err++; $display("FAIL cfg_cre_cycles: observed %0h required %0h", cre_c, 8); end
    n_cmp++;
    if (we_c !== 6) begin n_err++; $display("FAIL cfg_we_cycles: observed %0h required %0h", we_c, 6); end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
